// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - two-master (inst/data) to one-slave sram-like arbiter with in-order response routing
module sram_bus_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic        busy,
    output logic        err_orphan
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] PTR_LAST   = PW'(MAX_OUTSTANDING - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          lock_valid_q, lock_valid_d, lock_id_q, lock_id_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          err_orphan_q, err_orphan_d;

    logic full, empty, grant, grant_req, push, pop, head;

    // Grant, slave mux and response routing: all zero-latency paths.
    always_comb begin
        full  = (count_q == CNT_MAX);
        empty = (count_q == '0);
        if (lock_valid_q)
            grant = lock_id_q;
        else if (inst_req && starve_cnt_q == STARVE_MAX)
            grant = ID_INST;
        else if (!data_req)
            grant = ID_INST;
        else
            grant = ID_DATA;
        grant_req = (grant == ID_DATA) ? data_req : inst_req;
        head      = fifo_q[rd_ptr_q];

        bus_req   = !rst && grant_req && !full;
        push      = bus_req && bus_addr_ok;
        pop       = !rst && bus_data_ok && !empty;

        bus_wr    = !rst && ((grant == ID_DATA) ? data_wr : inst_wr);
        bus_size  = rst ? 2'b0  : ((grant == ID_DATA) ? data_size  : inst_size);
        bus_addr  = rst ? 32'b0 : ((grant == ID_DATA) ? data_addr  : inst_addr);
        bus_wstrb = rst ? 4'b0  : ((grant == ID_DATA) ? data_wstrb : inst_wstrb);
        bus_wdata = rst ? 32'b0 : ((grant == ID_DATA) ? data_wdata : inst_wdata);

        inst_addr_ok = push && (grant == ID_INST);
        data_addr_ok = push && (grant == ID_DATA);
        inst_data_ok = pop && (head == ID_INST);
        data_data_ok = pop && (head == ID_DATA);
        inst_rdata   = rst ? 32'b0 : bus_rdata;
        data_rdata   = rst ? 32'b0 : bus_rdata;
        busy         = !rst && !empty;
        err_orphan   = !rst && err_orphan_q;
    end

    always_comb begin
        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        starve_cnt_d = starve_cnt_q;
        if (push) begin
            fifo_d[wr_ptr_q] = grant;
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop)
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A presented-but-unaccepted request pins the grant; a dropped req releases it.
        lock_valid_d = bus_req && !bus_addr_ok;
        lock_id_d    = grant;
        if (!inst_req || (push && grant == ID_INST))
            starve_cnt_d = '0;
        else if (push && grant == ID_DATA && starve_cnt_q != STARVE_MAX)
            starve_cnt_d = starve_cnt_q + 1'b1;
        err_orphan_d = err_orphan_q || (bus_data_ok && empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            lock_valid_q <= 1'b0;
            lock_id_q    <= 1'b0;
            starve_cnt_q <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            lock_valid_q <= lock_valid_d;
            lock_id_q    <= lock_id_d;
            starve_cnt_q <= starve_cnt_d;
            err_orphan_q <= err_orphan_d;
        end
    end
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb/tb_sram_bus_arbiter.sv - directed and randomized self-checking bench for sram_bus_arbiter
module tb_sram_bus_arbiter;
    localparam int MAXO = 2;
    localparam int SL   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, bus_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [3:0]  inst_wstrb, data_wstrb, bus_wstrb;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        busy, err_orphan;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .busy(busy), .err_orphan(err_orphan)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: queue of issuers in order, waiting-master memory, starvation tally.
    bit mq[$];
    int m_starve;
    bit m_pending_v, m_pending_who, m_orphan;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    endtask

    task automatic idle();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wstrb = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wstrb = 0; data_wdata = 0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    endtask

    // Called at the negedge: compare against the model, then advance it across the posedge.
    task automatic tick();
        bit full, who, req_sel, exp_req, acc_i, acc_d;
        if (rst) begin
            check("rst_ctl", {bus_req, bus_wr, bus_size, bus_wstrb, inst_addr_ok, data_addr_ok,
                              inst_data_ok, data_data_ok, busy, err_orphan}, 32'd0);
            check("rst_addr", bus_addr, 32'd0);
            check("rst_wdata", bus_wdata, 32'd0);
            check("rst_rdata", inst_rdata | data_rdata, 32'd0);
            @(posedge clk);
            mq.delete(); m_starve = 0; m_pending_v = 0; m_pending_who = 0; m_orphan = 0;
        end else begin
            full = (mq.size() == MAXO);
            if (m_pending_v) who = m_pending_who;
            else if (inst_req && m_starve >= SL) who = 0;
            else if (!data_req) who = 0;
            else who = 1;
            req_sel = who ? data_req : inst_req;
            exp_req = req_sel && !full;
            acc_i = exp_req && bus_addr_ok && !who;
            acc_d = exp_req && bus_addr_ok && who;
            check("bus_req", bus_req, exp_req);
            check("inst_addr_ok", inst_addr_ok, acc_i);
            check("data_addr_ok", data_addr_ok, acc_d);
            check("inst_data_ok", inst_data_ok, bus_data_ok && mq.size() > 0 && mq[0] == 0);
            check("data_data_ok", data_data_ok, bus_data_ok && mq.size() > 0 && mq[0] == 1);
            check("busy", busy, mq.size() != 0);
            check("err_orphan", err_orphan, m_orphan);
            check("rdata", {inst_rdata ^ bus_rdata} | {data_rdata ^ bus_rdata}, 32'd0);
            if (exp_req) begin
                check("bus_addr", bus_addr, who ? data_addr : inst_addr);
                check("bus_wdata", bus_wdata, who ? data_wdata : inst_wdata);
                check("bus_attr", {bus_wr, bus_size, bus_wstrb},
                      who ? {data_wr, data_size, data_wstrb} : {inst_wr, inst_size, inst_wstrb});
            end
            @(posedge clk);
            if (bus_data_ok) begin
                if (mq.size() > 0) void'(mq.pop_front());
                else m_orphan = 1;
            end
            if (acc_i || acc_d) mq.push_back(who);
            m_pending_v = exp_req && !bus_addr_ok;
            m_pending_who = who;
            if (!inst_req || acc_i) m_starve = 0;
            else if (acc_d && m_starve < SL) m_starve++;
        end
        #1;
    endtask

    task automatic go();
        @(negedge clk);
        tick();
    endtask

    initial begin
        bit [9:0] seq;
        int nacc;
        idle();
        rst = 1;
        go(); go();
        rst = 0;
        go();

        // Single fetch
        inst_req = 1; inst_addr = 32'h1c00_0000; bus_addr_ok = 1;
        @(negedge clk);
        check("fetch_addr_ok", inst_addr_ok, 1'b1);
        check("fetch_bus_addr", bus_addr, 32'h1c00_0000);
        tick();
        inst_req = 0; bus_addr_ok = 0;
        @(negedge clk); check("fetch_busy", busy, 1'b1); tick();
        bus_data_ok = 1; bus_rdata = 32'h0280_0c0c;
        @(negedge clk);
        check("fetch_data_ok", inst_data_ok, 1'b1);
        check("fetch_rdata", inst_rdata, 32'h0280_0c0c);
        check("fetch_no_dok", data_data_ok, 1'b0);
        tick();
        bus_data_ok = 0;
        @(negedge clk); check("fetch_idle", busy, 1'b0); tick();

        // Simultaneous requests: data first
        inst_req = 1; inst_addr = 32'h1c00_0004; data_req = 1; data_addr = 32'h8000_0100;
        data_wr = 1; data_wstrb = 4'hf; data_wdata = 32'hdead_beef; bus_addr_ok = 1;
        @(negedge clk); check("sim_first_d", {inst_addr_ok, data_addr_ok}, 2'b01); tick();
        data_req = 0;
        @(negedge clk); check("sim_second_i", {inst_addr_ok, data_addr_ok}, 2'b10); tick();
        inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h1111_1111;
        @(negedge clk); check("sim_r0_data", {inst_data_ok, data_data_ok}, 2'b01); tick();
        bus_rdata = 32'h2222_2222;
        @(negedge clk); check("sim_r1_inst", {inst_data_ok, data_data_ok}, 2'b10); tick();
        bus_data_ok = 0; data_wr = 0;

        // Lock: data held while slave stalls, inst arrives mid-stall
        data_req = 1; data_addr = 32'h8000_0010;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) inst_req = 1;
            @(negedge clk);
            check("lock_addr", bus_addr, 32'h8000_0010);
            tick();
        end
        bus_addr_ok = 1;
        @(negedge clk);
        check("lock_accept", {data_addr_ok, bus_addr}, {1'b1, 32'h8000_0010});
        tick();
        data_req = 0;
        go();
        inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
        go(); go();
        bus_data_ok = 0;

        // Starvation limit
        inst_req = 1; data_req = 1; bus_addr_ok = 1;
        seq = '0; nacc = 0;
        for (int c = 0; c < 10; c++) begin
            bus_data_ok = (mq.size() != 0);
            @(negedge clk);
            if (data_addr_ok) begin seq = {seq[8:0], 1'b1}; nacc++; end
            else if (inst_addr_ok) begin seq = {seq[8:0], 1'b0}; nacc++; end
            tick();
        end
        check("starve_count", nacc, 10);
        check("starve_seq", {22'd0, seq}, {22'd0, 10'b1111011110});
        inst_req = 0; data_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
        go();
        bus_data_ok = 0;

        // Full
        data_req = 1; data_addr = 32'h8000_0200; bus_addr_ok = 1;
        go(); go();
        @(negedge clk); check("full_gate", {bus_req, data_addr_ok}, 2'b00); tick();
        bus_data_ok = 1;
        @(negedge clk); check("full_pop_same", bus_req, 1'b0); tick();
        bus_data_ok = 0;
        @(negedge clk); check("full_next_acc", {bus_req, data_addr_ok}, 2'b11); tick();

        // Reset with 2 outstanding, then orphan
        inst_req = 1; bus_data_ok = 1; rst = 1;
        @(negedge clk); check("rst_busy", {bus_req, busy, data_data_ok}, 3'b000); tick();
        go();
        rst = 0; idle(); bus_data_ok = 1;
        @(negedge clk); check("orphan_no_dok", {inst_data_ok, data_data_ok}, 2'b00); tick();
        bus_data_ok = 0;
        @(negedge clk); check("orphan_flag", err_orphan, 1'b1); tick();

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            rst         = ($urandom_range(0, 79) == 0);
            inst_req    = ($urandom_range(0, 9) < 7);
            data_req    = ($urandom_range(0, 9) < 6);
            inst_wr     = $urandom; inst_size = 2'($urandom); inst_wstrb = 4'($urandom);
            inst_addr   = $urandom; inst_wdata = $urandom;
            data_wr     = $urandom; data_size = 2'($urandom); data_wstrb = 4'($urandom);
            data_addr   = $urandom; data_wdata = $urandom;
            bus_addr_ok = ($urandom_range(0, 9) < 6);
            bus_data_ok = (mq.size() != 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 49) == 0);
            bus_rdata   = $urandom;
            go();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        if (n_pass != n_total) $error("checks did not all pass");
        $finish;
    end
endmodule
